output_fifo_buffer: RTL
=======================

// Module: output_fifo_buffer
// PURPOSE
//  Parametrised output buffer between the crossbar output and the link to the next router (or NI).
//  Holds up to DEPTH flits in a first-word-fall-through FIFO and presents them with valid.
//  Pops only when the downstream ready_in is high; the previous buffer had no backpressure, so this is new.
//  Reports full/almost_full to the switch allocator, plus a sticky overflow error and an occupancy count.
// PARAMETERS
//  DATA_WIDTH   `DATA_WIDTH (32)  flit width including parity bit
//  DEPTH        4                 flit slots; power of two, >= 2
//  AF_LEVEL     DEPTH-1           count >= AF_LEVEL asserts almost_full; 1..DEPTH
//  PTR_W        $clog2(DEPTH)     pointer width (derived; do not override)
// PORTS
//  clk          in   1            single clock, rising edge
//  rst          in   1            synchronous reset, active-high
//  enable       in   1            write strobe from crossbar (flit present on data_in)
//  data_in      in   DATA_WIDTH   flit from crossbar
//  ready_in     in   1            downstream can accept a flit this cycle
//  data_out     out  DATA_WIDTH   head flit (to link / parity checker)
//  valid        out  1            data_out holds a real flit
//  full         out  1            count == DEPTH
//  almost_full  out  1            count >= AF_LEVEL
//  count        out  PTR_W+1      current occupancy, 0..DEPTH
//  overflow     out  1            sticky: a write was attempted while full and not popping
// BEHAVIOUR
//  - Reset (rst=1 at a rising edge):
//    * wr_ptr=rd_ptr=0, count=0, valid=0, full=0, almost_full=0, overflow=0.
//    * data_out=0 while valid=0; storage contents are don't-care.
//    * Reset wins over every same-cycle write or pop; in-flight flits are discarded.
//  - push = enable & (~full | pop).
//    * When full, a simultaneous pop frees the slot and the write is accepted.
//  - pop = valid & ready_in. A flit is transferred on every edge where pop is high.
//  - Write at edge N: data is visible on data_out/valid after edge N if the FIFO was empty, so latency is 1 cycle.
//    There is no combinational data_in->data_out path.
//  - data_out = mem[rd_ptr] when valid, else 0. valid = (count != 0). It must not change while valid & ~ready_in.
//  - Counter update per edge:
//    * push & ~pop: count+1.
//    * pop & ~push: count-1.
//    * both or neither: count unchanged.
//  - Pointers: wr_ptr increments on push, rd_ptr increments on pop. Both wrap modulo DEPTH (natural PTR_W overflow).
//  - full, almost_full and valid are registered and derived from the next-state count. They are glitch-free and
//    updated at the same edge as count.
//  - enable & full & ~pop: the flit is dropped, storage and pointers are unchanged, and overflow is set to 1.
//    overflow clears only on rst.
//  - ready_in is ignored when valid=0, and an empty FIFO never underflows.
//  - enable=0: data_in is ignored (may be X).
// STRUCTURE
//  - parameters.v (shared include): DATA_WIDTH and a new BUFFER_DEPTH default. The DEPTH default references it.
//  - One natural sub-module: fifo_ptr_ctrl, which holds the pointers, count, full/almost_full/valid logic and
//    overflow flag. The top level holds only the storage array and the data_out mux.
//  - Storage is a reg array written on push only and is not reset, so it maps to distributed RAM on FPGA.
// TESTING
//  - Reset check: hold rst 2 cycles with enable=1.
//    -> valid=0, count=0, full=0, overflow=0, data_out=0.
//  - Basic flow, ready_in=1, DEPTH=4: write A1,A2,A3 on consecutive cycles.
//    -> A1 appears one cycle after its write, then A2 and A3 in order; count never exceeds 1; valid drops after A3.
//  - Fill and block, ready_in=0: write 5 flits 0x10..0x14.
//    -> count=4 and full=1 after the 4th; almost_full=1 at count 3; the 5th is dropped and overflow=1;
//       data_out holds 0x10 stable.
//  - Full with simultaneous pop: FIFO full, ready_in=1 and enable=1 with 0x20.
//    -> 0x10 popped, 0x20 accepted, count stays 4, overflow unchanged.
//  - Wrap-around: 3 x (write 6, ready_in toggled 1/0 each cycle) with random data.
//    -> output order equals input order across pointer wrap; a scoreboard checks no loss or duplication.
//  - Reset mid-operation: count=3, assert rst for 1 cycle with enable=1 and ready_in=1.
//    -> count=0, valid=0 next cycle; the next write appears as the head after 1 cycle.

Source files
------------

// File: rtl/output_fifo_buffer_pkg.sv
// Shared defaults and helpers for the router output FIFO buffer.
// The counter-operation encoding is shared by the pointer controller.
package output_fifo_buffer_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int BUFFER_DEPTH   = 4;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // Simultaneous push and pop leave the occupancy unchanged.
  function automatic cnt_op_e cnt_op(input logic push, input logic pop);
    cnt_op_e op;
    case ({push, pop})
      2'b10:   op = CNT_INC;
      2'b01:   op = CNT_DEC;
      default: op = CNT_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/output_fifo_buffer_fifo_ptr_ctrl.sv
// Pointer, occupancy and status control for the output FIFO.
// All status flags are registered from the next-state count.
module fifo_ptr_ctrl
  import output_fifo_buffer_pkg::*;
#(
  parameter int DEPTH    = BUFFER_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int PTR_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             ready_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic             push_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             almost_full_o,
  output logic [PTR_W:0]   count_o,
  output logic             overflow_o
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic             af_q, af_d;
  logic             overflow_q, overflow_d;
  logic             push, pop;

  // Next-state logic: a pop in the same cycle frees a slot for a write into a full FIFO.
  always_comb begin
    pop  = valid_q & ready_i;
    push = enable_i & (~full_q | pop);

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case (cnt_op(push, pop))
      CNT_INC: count_d = count_q + CNT_W'(1);
      CNT_DEC: count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    valid_d    = (count_d != '0);
    full_d     = (count_d == DEPTH_C);
    af_d       = (count_d >= AF_C);
    overflow_d = overflow_q | (enable_i & full_q & ~pop);
  end

  // State registers; reset discards every in-flight flit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      full_q     <= 1'b0;
      af_q       <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      full_q     <= full_d;
      af_q       <= af_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_ptr_o      = wr_ptr_q;
  assign rd_ptr_o      = rd_ptr_q;
  assign push_o        = push;
  assign valid_o       = valid_q;
  assign full_o        = full_q;
  assign almost_full_o = af_q;
  assign count_o       = count_q;
  assign overflow_o    = overflow_q;

endmodule

// File: rtl/output_fifo_buffer.sv
// First-word-fall-through output buffer between crossbar and outgoing link.
// Holds the storage array and head mux; control lives in fifo_ptr_ctrl.
module output_fifo_buffer
  import output_fifo_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = BUFFER_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  full,
  output logic                  almost_full,
  output logic [PTR_W:0]        count,
  output logic                  overflow
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  push;

  fifo_ptr_ctrl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .PTR_W    (PTR_W)
  ) u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable),
    .ready_i       (ready_in),
    .wr_ptr_o      (wr_ptr),
    .rd_ptr_o      (rd_ptr),
    .push_o        (push),
    .valid_o       (valid),
    .full_o        (full),
    .almost_full_o (almost_full),
    .count_o       (count),
    .overflow_o    (overflow)
  );

  // Storage is left unreset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr] <= data_in;
    end
  end

  // Head flit is forced to zero whenever nothing valid is held.
  always_comb begin
    if (valid) begin
      data_out = mem_q[rd_ptr];
    end else begin
      data_out = '0;
    end
  end

endmodule
